// File: rtl/fadd_pipe.sv
// Pipelined floating-point add/subtract with flush-to-zero, RNE rounding and exception flags.
// Input stage, two datapath stages and an output register: results appear three unstalled edges after acceptance.
module fadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   sub,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   ovf,
  output logic                   uf,
  output logic                   inv
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;
  localparam int EW  = EXP_W + 2;
  localparam int SHW = $clog2(SW);
  localparam int LZW = $clog2(SW + 1);
  localparam int unsigned SAT = MAN_W + 3;
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);

  // ---------------- S1: unpack, classify, order by magnitude ----------------
  logic [W-1:0]     a, b, c1_spec_y;
  logic             a_zero, b_zero, a_max, b_max, a_nan, b_nan, a_inf, b_inf, swap, c1_inv;
  logic [W-2:0]     key_a, key_b;
  logic [SW-1:0]    man_a, man_b;
  logic [EXP_W-1:0] diff;
  logic [SHW-1:0]   c1_shamt;

  always_comb begin
    a      = x1;
    b      = {x2[W-1] ^ sub, x2[W-2:0]};
    a_zero = (a[W-2:MAN_W] == '0);
    b_zero = (b[W-2:MAN_W] == '0);
    a_max  = &a[W-2:MAN_W];
    b_max  = &b[W-2:MAN_W];
    a_nan  = a_max & (|a[MAN_W-1:0]);
    b_nan  = b_max & (|b[MAN_W-1:0]);
    a_inf  = a_max & ~(|a[MAN_W-1:0]);
    b_inf  = b_max & ~(|b[MAN_W-1:0]);
    key_a  = a_zero ? '0 : a[W-2:0];
    key_b  = b_zero ? '0 : b[W-2:0];
    man_a  = a_zero ? '0 : {2'b01, a[MAN_W-1:0], 2'b00};
    man_b  = b_zero ? '0 : {2'b01, b[MAN_W-1:0], 2'b00};
    swap   = (key_b > key_a);
    diff   = swap ? (b[W-2:MAN_W] - a[W-2:MAN_W]) : (a[W-2:MAN_W] - b[W-2:MAN_W]);
    c1_shamt = (32'(diff) > SAT) ? SHW'(SAT) : SHW'(diff);
    c1_inv = a_nan | b_nan | (a_inf & b_inf & (a[W-1] ^ b[W-1]));
    if (a_nan)
      c1_spec_y = {a[W-1], {EXP_W{1'b1}}, 1'b1, a[MAN_W-2:0]};
    else if (b_nan)
      c1_spec_y = {b[W-1], {EXP_W{1'b1}}, 1'b1, b[MAN_W-2:0]};
    else if (a_inf & b_inf & (a[W-1] ^ b[W-1]))
      c1_spec_y = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (a_inf)
      c1_spec_y = a;
    else
      c1_spec_y = b;
  end

  logic             s1_valid, s1_sign, s1_eff_sub, s1_special, s1_inv;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_man_l, s1_man_s;
  logic [SHW-1:0]   s1_shamt;
  logic [W-1:0]     s1_spec_y;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_eff_sub <= 1'b0;
      s1_special <= 1'b0;
      s1_inv     <= 1'b0;
      s1_exp     <= '0;
      s1_man_l   <= '0;
      s1_man_s   <= '0;
      s1_shamt   <= '0;
      s1_spec_y  <= '0;
    end else if (!stall) begin
      s1_valid   <= in_valid;
      s1_sign    <= swap ? b[W-1] : a[W-1];
      s1_eff_sub <= a[W-1] ^ b[W-1];
      s1_special <= a_max | b_max;
      s1_inv     <= c1_inv;
      s1_exp     <= swap ? b[W-2:MAN_W] : a[W-2:MAN_W];
      s1_man_l   <= swap ? man_b : man_a;
      s1_man_s   <= swap ? man_a : man_b;
      s1_shamt   <= c1_shamt;
      s1_spec_y  <= c1_spec_y;
    end
  end

  // ---------------- S2: align, add/sub, carry normalise, LZC ----------------
  logic [2*SW-1:0] ext;
  logic [SW:0]     sum;
  logic [SW-1:0]   nsum;
  logic [LZW-1:0]  lzc;

  // Sticky rides as an extra LSB so subtraction yields floor(exact) with a nonzero-remainder bit.
  always_comb begin
    ext  = {s1_man_s, {SW{1'b0}}} >> s1_shamt;
    sum  = s1_eff_sub ? ({s1_man_l, 1'b0} - {ext[2*SW-1:SW], |ext[SW-1:0]})
                      : ({s1_man_l, 1'b0} + {ext[2*SW-1:SW], |ext[SW-1:0]});
    nsum = sum[SW] ? {sum[SW:2], |sum[1:0]} : sum[SW-1:0];
    lzc  = LZW'(SW);
    for (int unsigned i = 0; i < SW; i++)
      if (nsum[i]) lzc = LZW'(SW - 1 - i);
  end

  logic                 s2_valid, s2_sign, s2_zero, s2_special, s2_inv;
  logic signed [EW-1:0] s2_exp;
  logic [SW-1:0]        s2_man;
  logic [LZW-1:0]       s2_lzc;
  logic [W-1:0]         s2_spec_y;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_zero    <= 1'b0;
      s2_special <= 1'b0;
      s2_inv     <= 1'b0;
      s2_exp     <= '0;
      s2_man     <= '0;
      s2_lzc     <= '0;
      s2_spec_y  <= '0;
    end else if (!stall) begin
      s2_valid   <= s1_valid;
      s2_zero    <= (nsum == '0);
      s2_sign    <= (nsum == '0) ? (s1_sign & ~s1_eff_sub) : s1_sign;
      s2_special <= s1_special;
      s2_inv     <= s1_inv;
      s2_exp     <= $signed({2'b00, s1_exp}) + $signed({{(EW-1){1'b0}}, sum[SW]});
      s2_man     <= nsum;
      s2_lzc     <= lzc;
      s2_spec_y  <= s1_spec_y;
    end
  end

  // ---------------- S3: normalise, round, pack, specials ----------------
  logic [SW-1:0]        m;
  logic signed [EW-1:0] exp_n, exp_r;
  logic                 rnd;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     frac_r;
  logic [W-1:0]         c3_y;
  logic                 c3_ovf, c3_uf, c3_inv;

  always_comb begin
    m      = s2_man << s2_lzc;
    exp_n  = s2_exp - $signed({{(EW-LZW){1'b0}}, s2_lzc});
    rnd    = m[2] & (m[3] | (|m[1:0]));
    mant_r = {1'b0, m[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd};
    exp_r  = exp_n + $signed({{(EW-1){1'b0}}, mant_r[MAN_W+1]});
    frac_r = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    c3_y   = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    c3_ovf = 1'b0;
    c3_uf  = 1'b0;
    c3_inv = 1'b0;
    if (s2_special) begin
      c3_y   = s2_spec_y;
      c3_inv = s2_inv;
    end else if (s2_zero) begin
      c3_y = {s2_sign, {(W-1){1'b0}}};
    end else if (exp_r >= EMAX_S) begin
      c3_y   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c3_ovf = 1'b1;
    end else if (exp_r < ONE_S) begin
      c3_y  = {s2_sign, {(W-1){1'b0}}};
      c3_uf = 1'b1;
    end
  end

  logic         s3_valid, s3_ovf, s3_uf, s3_inv;
  logic [W-1:0] s3_y;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_valid <= 1'b0;
      s3_y     <= '0;
      s3_ovf   <= 1'b0;
      s3_uf    <= 1'b0;
      s3_inv   <= 1'b0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      s3_y     <= c3_y;
      s3_ovf   <= c3_ovf;
      s3_uf    <= c3_uf;
      s3_inv   <= c3_inv;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
      uf        <= 1'b0;
      inv       <= 1'b0;
    end else if (!stall) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        y   <= s3_y;
        ovf <= s3_ovf;
        uf  <= s3_uf;
        inv <= s3_inv;
      end
    end
  end
endmodule

// File: tb/tb_fadd_pipe.sv
// Self-checking bench for fadd_pipe (single precision): directed vectors plus randomized stream
// against an exact wide-integer reference of IEEE add with flush-to-zero.
module tb_fadd_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic        clk = 1'b0;
  logic        rstn, in_valid, stall, sub;
  logic [31:0] x1, x2;
  logic        out_valid, ovf, uf, inv;
  logic [31:0] y;

  fadd_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .stall(stall), .sub(sub),
    .x1(x1), .x2(x2), .out_valid(out_valid), .y(y), .ovf(ovf), .uf(uf), .inv(inv)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Exact reference: operands as integers on a common scale, then a single RNE rounding.
  function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] bx, input logic s);
    logic [31:0]  b;
    logic         sa, sb, sg;
    int           ea, eb, emin, p, be, k;
    logic [299:0] ma, mb, mag, q, rem, half;
    b  = bx ^ {s, 31'b0};
    sa = a[31];
    sb = b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 && a[22:0] != 0) return {a | 32'h0040_0000, 3'b001};
    if (eb == 255 && b[22:0] != 0) return {b | 32'h0040_0000, 3'b001};
    if (ea == 255 && eb == 255 && sa != sb) return {32'hFFC0_0000, 3'b001};
    if (ea == 255) return {a, 3'b000};
    if (eb == 255) return {b, 3'b000};
    ma = (ea == 0) ? '0 : 300'({1'b1, a[22:0]});
    mb = (eb == 0) ? '0 : 300'({1'b1, b[22:0]});
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    emin = (ea < eb) ? ea : eb;
    ma = ma << (ea - emin);
    mb = mb << (eb - emin);
    if (sa == sb) begin
      mag = ma + mb; sg = sa;
    end else if (ma > mb) begin
      mag = ma - mb; sg = sa;
    end else begin
      mag = mb - ma; sg = sb;
    end
    if (mag == '0) return {sa & sb, 31'd0, 3'b000};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    be = p + emin - 23;
    if (p > 23) begin
      k    = p - 23;
      q    = mag >> k;
      rem  = mag & ((300'd1 << k) - 300'd1);
      half = 300'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 300'd1;
      if (q[24]) begin
        q  = q >> 1;
        be = be + 1;
      end
    end else begin
      q = mag << (23 - p);
    end
    if (be >= 255) return {sg, 8'hFF, 23'd0, 3'b100};
    if (be <= 0) return {sg, 31'd0, 3'b010};
    return {sg, 8'(be), q[22:0], 3'b000};
  endfunction

  typedef struct packed {
    logic [31:0] y;
    logic [2:0]  fl;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned ue = 0;
  logic [31:0] held_y = '0;
  logic [2:0]  held_fl = '0;
  bit          chk_en = 1'b0;
  bit          dir_en = 1'b0;
  logic [31:0] dir_y = '0;
  logic [2:0]  dir_fl = '0;

  // Expected-output model: an op accepted on unstalled edge k is visible once k+3 unstalled edges have passed.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      held_y  <= '0;
      held_fl <= '0;
    end else if (!stall) begin
      int unsigned nu;
      logic [34:0] r;
      nu = ue + 1;
      ue <= nu;
      while (q.size() > 0 && q[0].due < nu) void'(q.pop_front());
      if (q.size() > 0 && q[0].due == nu) begin
        held_y  <= q[0].y;
        held_fl <= q[0].fl;
      end
      if (in_valid) begin
        r = dir_en ? {dir_y, dir_fl} : ref_add(x1, x2, sub);
        q.push_back('{y: r[34:3], fl: r[2:0], due: nu + 3});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 64'(out_valid), 64'(q.size() > 0 && q[0].due == ue));
      check("y", 64'(y), 64'(held_y));
      check("flags{ovf,uf,inv}", 64'({ovf, uf, inv}), 64'(held_fl));
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input bit d, input logic [31:0] ey, input logic [2:0] ef);
    @(negedge clk);
    stall = 1'b0; in_valid = 1'b1; x1 = a; x2 = b; sub = s;
    dir_en = d; dir_y = ey; dir_fl = ef;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      stall = 1'b0; in_valid = 1'b0; dir_en = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 9))
      0: begin
        v[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) v[22:0] = '0;
      end
      1: v[30:23] = 8'h00;
      2: v[30:23] = 8'hFE;
      3: v[30:23] = 8'h01;
      4: v[30:23] = 8'h7F;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rstn = 1'b0; in_valid = 1'b0; stall = 1'b0; sub = 1'b0; x1 = '0; x2 = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    #2 rstn = 1'b1;

    op(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h4040_0000, 3'b000);
    idle(4);
    op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b1, 32'h0000_0000, 3'b000);
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 3'b000);
    op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 1'b1, 32'h7F80_0000, 3'b100);
    op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b1, 32'hFFC0_0000, 3'b001);
    op(32'h3F80_0000, 32'h3380_0000, 1'b0, 1'b1, 32'h3F80_0000, 3'b000);
    op(32'h3F80_0000, 32'h3380_0001, 1'b0, 1'b1, 32'h3F80_0001, 3'b000);
    op(32'h0080_0000, 32'h0080_0001, 1'b1, 1'b1, 32'h8000_0000, 3'b010);
    op(32'h7FA0_0001, 32'h3F80_0000, 1'b0, 1'b1, 32'h7FE0_0001, 3'b001);
    op(32'h3F80_0000, 32'hFF81_2345, 1'b0, 1'b1, 32'hFFC1_2345, 3'b001);
    op(32'hFF80_0000, 32'h3F80_0000, 1'b0, 1'b1, 32'hFF80_0000, 3'b000);
    op(32'h4000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h4000_0000, 3'b000);
    idle(4);

    // Stream of four with a two-cycle stall; in_valid stays high during the stall and must be ignored.
    op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b1, 32'h4000_0000, 3'b000);
    op(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h4080_0000, 3'b000);
    @(negedge clk);
    stall = 1'b1; in_valid = 1'b1; x1 = 32'h4120_0000; x2 = 32'h4120_0000; dir_en = 1'b0;
    @(negedge clk);
    op(32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b1, 32'h4000_0000, 3'b000);
    op(32'h3FC0_0000, 32'h3E80_0000, 1'b0, 1'b1, 32'h3FE0_0000, 3'b000);
    idle(5);

    // Reset with two operations in flight.
    op(32'h4100_0000, 32'h4100_0000, 1'b0, 1'b1, 32'h4180_0000, 3'b000);
    op(32'h4110_0000, 32'h4100_0000, 1'b0, 1'b1, 32'h4188_0000, 3'b000);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_flags", 64'({ovf, uf, inv}), 64'd0);
    idle(2);
    #2 rstn = 1'b1;
    idle(6);

    repeat (3000) begin
      @(negedge clk);
      ra = rand_fp();
      if ($urandom_range(0, 2) == 0)
        rb = {ra[31] ^ 1'(($urandom_range(0, 1))), ra[30:23] + 8'($urandom_range(0, 2)), ra[22:0] ^ 23'($urandom_range(0, 15))};
      else
        rb = rand_fp();
      rs = 1'($urandom_range(0, 1));
      if (rb[30:23] == 8'hFF && rb[22:0] != '0) rs = 1'b0;
      stall = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      x1 = ra; x2 = rb; sub = rs; dir_en = 1'b0;
    end
    idle(6);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
